// File: rtl/ce_period_monitor.sv
// rtl/ce_period_monitor.sv - measures the interval between ce_in strobes, flags early/lost ticks, reports lock
// Optional min/max period statistics are enabled by defining CE_MON_STATS_EN.
module ce_period_monitor #(
    parameter int FCLK     = 50000000,
    parameter int FTICK    = 1000,
    parameter int TOL      = 16,
    parameter int W        = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce_in,
    input  logic         clr,
    output logic [W-1:0] period,
    output logic         period_vld,
    output logic         err_early,
    output logic         err_lost,
    output logic         locked
`ifdef CE_MON_STATS_EN
    ,
    output logic [W-1:0] min_period,
    output logic [W-1:0] max_period
`endif
);

    localparam int EXP = FCLK / FTICK;
    localparam logic [W-1:0] LO_LIM = (EXP > TOL) ? W'(EXP - TOL) : '0;
    localparam logic [W-1:0] HI_LIM = W'(EXP + TOL);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOST  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  period_q, period_d;
    logic          vld_q, vld_d;
    logic          early_q, early_d;
    logic          lost_q, lost_d;
    logic [GW-1:0] good_q, good_d;
    logic          locked_q, locked_d;

    logic measure;
    logic timeout;
    logic too_early;

    // A tick on the timeout cycle is a normal measurement, so timeout requires !ce_in.
    assign measure   = (state_q == S_ARMED) && ce_in;
    assign timeout   = (state_q == S_ARMED) && !ce_in && (cnt_q == HI_LIM);
    assign too_early = measure && (cnt_q < LO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ce_in) state_d = S_ARMED;
            S_ARMED: if (timeout) state_d = S_LOST;
            S_LOST:  if (ce_in) state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = ce_in ? W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
        period_d = measure ? cnt_q : period_q;
        vld_d    = measure;
        early_d  = too_early | (early_q & ~clr);
        lost_d   = timeout | (lost_q & ~clr);
        good_d   = good_q;
        if (too_early || timeout) begin
            good_d = '0;
        end else if (measure && (good_q != GOOD_MAX)) begin
            good_d = good_q + 1'b1;
        end
        locked_d = (good_d == GOOD_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            early_q  <= 1'b0;
            lost_q   <= 1'b0;
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            early_q  <= early_d;
            lost_q   <= lost_d;
            good_q   <= good_d;
            locked_q <= locked_d;
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign err_early  = early_q;
    assign err_lost   = lost_q;
    assign locked     = locked_q;

`ifdef CE_MON_STATS_EN
    logic [W-1:0] min_q, min_d;
    logic [W-1:0] max_q, max_d;

    // clr restarts the extremes first, so a simultaneous measurement becomes both min and max.
    always_comb begin
        min_d = clr ? '1 : min_q;
        max_d = clr ? '0 : max_q;
        if (measure) begin
            if (cnt_q < min_d) min_d = cnt_q;
            if (cnt_q > max_d) max_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`endif

endmodule

// File: tb/tb_ce_period_monitor.sv
// tb/tb_ce_period_monitor.sv - self-checking bench for ce_period_monitor with a timestamp-based reference model
module tb_ce_period_monitor;

    localparam int FCLK = 1000;
    localparam int FTICK = 100;
    localparam int TOL = 1;
    localparam int W = 8;
    localparam int LOCK_CNT = 4;
    localparam int EXP = FCLK / FTICK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce_in = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] period;
    logic         period_vld;
    logic         err_early;
    logic         err_lost;
    logic         locked;
`ifdef CE_MON_STATS_EN
    logic [W-1:0] min_period;
    logic [W-1:0] max_period;
`endif

    int checks = 0;
    int errors = 0;

    ce_period_monitor #(
        .FCLK(FCLK), .FTICK(FTICK), .TOL(TOL), .W(W), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce_in(ce_in),
        .clr(clr),
        .period(period),
        .period_vld(period_vld),
        .err_early(err_early),
        .err_lost(err_lost),
        .locked(locked)
`ifdef CE_MON_STATS_EN
        ,
        .min_period(min_period),
        .max_period(max_period)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks absolute tick timestamps rather than a running counter.
    int       cyc = 0;
    int       m_mode = 0;
    int       m_last = 0;
    int       m_good = 0;
    int       el;
    logic [W-1:0] m_period = '0;
    logic [W-1:0] m_min = '1;
    logic [W-1:0] m_max = '0;
    bit       m_vld = 0, m_early = 0, m_lost = 0, m_locked = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0; m_good = 0; m_period = '0; m_vld = 0;
                m_early = 0; m_lost = 0; m_locked = 0; m_min = '1; m_max = '0;
            end else begin
                el = cyc - m_last;
                m_vld = 0;
                if (clr) begin
                    m_early = 0; m_lost = 0; m_min = '1; m_max = '0;
                end
                if (ce_in) begin
                    if (m_mode == 1) begin
                        m_period = W'(el);
                        m_vld = 1;
                        if (el < EXP - TOL) begin
                            m_early = 1; m_good = 0;
                        end else if (m_good < LOCK_CNT) begin
                            m_good++;
                        end
                        if (el < m_min) m_min = W'(el);
                        if (el > m_max) m_max = W'(el);
                    end
                    m_mode = 1;
                    m_last = cyc;
                end else if (m_mode == 1 && el == EXP + TOL) begin
                    m_lost = 1; m_good = 0; m_mode = 2;
                end
                m_locked = (m_good == LOCK_CNT);
            end
            cyc++;
        end
    end

    task automatic cyc_drive(input bit ce, input bit c);
        @(negedge clk);
        ce_in = ce;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // n-1 quiet cycles then one tick; clr is pulsed on cycle index clr_at
    task automatic gap(input int n, input int clr_at);
        for (int i = 0; i < n; i++) cyc_drive(i == n - 1, i == clr_at);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc_drive(1'b0, 1'b0);
        checks++;
        if ({period, period_vld, err_early, err_lost, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: period=%0d vld=%0b early=%0b lost=%0b locked=%0b expected all 0",
                     period, period_vld, err_early, err_lost, locked);
        end
`ifdef CE_MON_STATS_EN
        checks++;
        if (min_period !== 8'hFF || max_period !== 8'h00) begin
            errors++;
            $display("FAIL reset_stats: min=%0h max=%0h expected ff/0", min_period, max_period);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock();
        int lock_at = 0;
        cyc_drive(1'b1, 1'b0);
        checks++;
        if (period_vld !== 1'b0) begin
            errors++;
            $display("FAIL arm_no_vld: vld=%0b expected 0", period_vld);
        end
        for (int k = 1; k <= 5; k++) begin
            gap(EXP, -1);
            checks++;
            if (period_vld !== 1'b1 || period !== 8'd10 || period !== m_period) begin
                errors++;
                $display("FAIL lock_period k=%0d: vld=%0b period=%0d expected 1/10", k, period_vld, period);
            end
            if (locked && lock_at == 0) lock_at = k;
        end
        checks++;
        if (lock_at != LOCK_CNT || err_early !== 1'b0 || err_lost !== 1'b0) begin
            errors++;
            $display("FAIL lock_rise: lock_at=%0d early=%0b lost=%0b expected 4/0/0", lock_at, err_early, err_lost);
        end
    endtask

    task automatic test_early();
        gap(8, -1);
        checks++;
        if (period_vld !== 1'b1 || period !== 8'd8 || err_early !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL early_tick: vld=%0b period=%0d early=%0b locked=%0b expected 1/8/1/0",
                     period_vld, period, err_early, locked);
        end
        gap(EXP, 0);
        checks++;
        if (err_early !== 1'b0 || period !== 8'd10) begin
            errors++;
            $display("FAIL early_clr: early=%0b period=%0d expected 0/10", err_early, period);
        end
        for (int k = 1; k <= 3; k++) begin
            gap(EXP, -1);
            checks++;
            if (locked !== (k == 3) || locked !== m_locked) begin
                errors++;
                $display("FAIL relock k=%0d: locked=%0b expected %0b", k, locked, k == 3);
            end
        end
    endtask

    task automatic test_lost();
        int first = 0;
        logic [W-1:0] held;
        held = period;
        for (int i = 1; i <= 20; i++) begin
            cyc_drive(1'b0, 1'b0);
            if (err_lost && first == 0) first = i;
        end
        checks++;
        if (first != EXP + TOL || locked !== 1'b0) begin
            errors++;
            $display("FAIL lost_timing: first=%0d locked=%0b expected 11/0", first, locked);
        end
        cyc_drive(1'b1, 1'b0);
        checks++;
        if (period_vld !== 1'b0 || period !== held) begin
            errors++;
            $display("FAIL lost_rearm: vld=%0b period=%0d expected 0/%0d", period_vld, period, held);
        end
        gap(EXP, -1);
        checks++;
        if (period_vld !== 1'b1 || period !== 8'd10 || err_lost !== 1'b1) begin
            errors++;
            $display("FAIL lost_resume: vld=%0b period=%0d lost=%0b expected 1/10/1", period_vld, period, err_lost);
        end
    endtask

    task automatic test_window();
        int gaps[3] = '{11, 9, 10};
        for (int k = 0; k < 3; k++) begin
            gap(gaps[k], (k == 0) ? 0 : -1);
            checks++;
            if (period_vld !== 1'b1 || period !== W'(gaps[k]) || err_lost !== 1'b0 || err_early !== 1'b0) begin
                errors++;
                $display("FAIL window gap=%0d: vld=%0b period=%0d lost=%0b early=%0b expected 1/%0d/0/0",
                         gaps[k], period_vld, period, err_lost, err_early, gaps[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_drive(1'b1, 1'b0);
        cyc_drive(1'b1, 1'b0);
        checks++;
        if (period_vld !== 1'b1 || period !== 8'd1 || err_early !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: vld=%0b period=%0d early=%0b locked=%0b expected 1/1/1/0",
                     period_vld, period, err_early, locked);
        end
    endtask

    task automatic test_async_reset();
        gap(EXP, 0);
        repeat (4) gap(EXP, -1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lock: locked=%0b expected 1", locked);
        end
        repeat (3) cyc_drive(1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({period, period_vld, err_early, err_lost, locked} !== '0) begin
            errors++;
            $display("FAIL async_reset: period=%0d vld=%0b early=%0b lost=%0b locked=%0b expected all 0",
                     period, period_vld, err_early, err_lost, locked);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc_drive(1'b1, 1'b0);
        checks++;
        if (period_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_rearm: vld=%0b expected 0", period_vld);
        end
        gap(EXP, -1);
        checks++;
        if (period_vld !== 1'b1 || period !== 8'd10) begin
            errors++;
            $display("FAIL reset_resume: vld=%0b period=%0d expected 1/10", period_vld, period);
        end
    endtask

    task automatic test_random();
        int n;
        for (int g = 0; g < 200; g++) begin
            n = ($urandom_range(0, 9) < 6) ? $urandom_range(EXP - TOL, EXP + TOL) : $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                cyc_drive(i == n - 1, $urandom_range(0, 15) == 0);
                checks++;
                if ({period_vld, period, err_early, err_lost, locked} !== {m_vld, m_period, m_early, m_lost, m_locked}) begin
                    errors++;
                    $display("FAIL random g=%0d: vld=%0b period=%0d early=%0b lost=%0b locked=%0b model %0b/%0d/%0b/%0b/%0b",
                             g, period_vld, period, err_early, err_lost, locked,
                             m_vld, m_period, m_early, m_lost, m_locked);
                end
`ifdef CE_MON_STATS_EN
                checks++;
                if (min_period !== m_min || max_period !== m_max) begin
                    errors++;
                    $display("FAIL random_stats g=%0d: min=%0d max=%0d model %0d/%0d", g, min_period, max_period, m_min, m_max);
                end
`endif
            end
        end
    endtask

`ifdef CE_MON_STATS_EN
    task automatic test_stats();
        gap(EXP, 0);
        gap(9, -1);
        gap(11, -1);
        checks++;
        if (min_period !== 8'd9 || max_period !== 8'd11) begin
            errors++;
            $display("FAIL stats_minmax: min=%0d max=%0d expected 9/11", min_period, max_period);
        end
        cyc_drive(1'b0, 1'b1);
        checks++;
        if (min_period !== 8'hFF || max_period !== 8'h00) begin
            errors++;
            $display("FAIL stats_clr: min=%0h max=%0h expected ff/0", min_period, max_period);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_lost();
        test_window();
        test_back_to_back();
        test_async_reset();
`ifdef CE_MON_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
